// File: rtl/sprite_plotter_pkg.sv
// Shared constants and types for the sprite plotter, the sprite shifter and the game-control FSM.
package sprite_plotter_pkg;

  localparam int unsigned SIDE  = 5;
  localparam int unsigned NPIX  = SIDE * SIDE;
  localparam int unsigned X_MAX = 160;
  localparam int unsigned Y_MAX = 120;
  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned C_W   = 3;
  localparam int unsigned CNT_W = $clog2(SIDE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Pac-Man facing direction shared with the shifter and control FSM.
  typedef enum logic [1:0] {
    ROT_RIGHT = 2'd0,
    ROT_UP    = 2'd1,
    ROT_LEFT  = 2'd2,
    ROT_DOWN  = 2'd3
  } rot_t;

  // Draw request captured on start; sprite is consumed MSB first.
  typedef struct packed {
    logic [NPIX-1:0] sprite;
    logic [X_W-1:0]  base_x;
    logic [Y_W-1:0]  base_y;
    logic [C_W-1:0]  fg_colour;
    logic [C_W-1:0]  bg_colour;
    logic            transparent;
    logic            erase;
  } req_t;

endpackage

// File: rtl/sprite_plotter_pixel_counter.sv
// Row/column walker over the SIDE x SIDE sprite with a last-pixel flag.
module pixel_counter
  import sprite_plotter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             last_c
);

  localparam logic [CNT_W-1:0] EDGE_MAX = CNT_W'(SIDE - 1);

  assign last_c = (row == EDGE_MAX) && (col == EDGE_MAX);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == EDGE_MAX) begin
        col <= '0;
        row <= last_c ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Walks a latched 5x5 sprite frame onto the VGA adapter write port, one pixel per clock,
// with transparent draw, erase and off-screen clipping.
module sprite_plotter
  import sprite_plotter_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [NPIX-1:0] sprite,
  input  logic [X_W-1:0]  base_x,
  input  logic [Y_W-1:0]  base_y,
  input  logic [C_W-1:0]  fg_colour,
  input  logic [C_W-1:0]  bg_colour,
  input  logic            transparent,
  input  logic            erase,
  output logic [X_W-1:0]  x,
  output logic [Y_W-1:0]  y,
  output logic [C_W-1:0]  colour,
  output logic            plot,
  output logic            busy,
  output logic            done
);

  state_t state, state_d;
  req_t   req, req_d;

  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;
  logic [C_W-1:0] colour_d;
  logic           plot_d, busy_d, done_d;

  logic             cnt_clear, cnt_advance, last_c;
  logic [CNT_W-1:0] row, col;
  logic [X_W:0]     xs;
  logic [Y_W:0]     ys;
  logic             pix_bit;

  pixel_counter u_pixel_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .row     (row),
    .col     (col),
    .last_c  (last_c)
  );

  // Screen coordinates carry one spare bit so the clip test sees overflow past the edge.
  always_comb begin
    xs      = {1'b0, req.base_x} + (X_W+1)'(col);
    ys      = {1'b0, req.base_y} + (Y_W+1)'(row);
    pix_bit = req.sprite[NPIX-1];
  end

  always_comb begin
    state_d     = state;
    req_d       = req;
    x_d         = x;
    y_d         = y;
    colour_d    = colour;
    plot_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          req_d = '{sprite: sprite, base_x: base_x, base_y: base_y,
                    fg_colour: fg_colour, bg_colour: bg_colour,
                    transparent: transparent, erase: erase};
          cnt_clear = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_DRAW;
        end
      end
      S_DRAW: begin
        busy_d       = 1'b1;
        cnt_advance  = 1'b1;
        req_d.sprite = req.sprite << 1;
        x_d          = xs[X_W-1:0];
        y_d          = ys[Y_W-1:0];
        colour_d     = (req.erase || !pix_bit) ? req.bg_colour : req.fg_colour;
        plot_d       = !(req.transparent && !req.erase && !pix_bit)
                       && (xs < (X_W+1)'(X_MAX)) && (ys < (Y_W+1)'(Y_MAX));
        if (last_c) state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      req    <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      req    <= req_d;
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
      plot   <= plot_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: draw, transparent, erase, clipping, start handling and reset.
module tb_sprite_plotter;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [24:0]  sprite;
  logic [7:0]   base_x;
  logic [6:0]   base_y;
  logic [2:0]   fg_colour;
  logic [2:0]   bg_colour;
  logic         transparent;
  logic         erase;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         plot;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  localparam logic [24:0] RIGHT_A = 25'b0111011111110001111101110;

  sprite_plotter dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .sprite      (sprite),
    .base_x      (base_x),
    .base_y      (base_y),
    .fg_colour   (fg_colour),
    .bg_colour   (bg_colour),
    .transparent (transparent),
    .erase       (erase),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full request; inputs are scrambled after the latch edge, poke re-pulses start mid-draw.
  task automatic run_draw(input int id, input logic [24:0] spr, input logic [7:0] bx,
                          input logic [6:0] by, input logic [2:0] fg, input logic [2:0] bg,
                          input logic tr, input logic er, input int poke, input int exp_plots);
    int plots;
    int r;
    int c;
    logic [8:0] ex;
    logic [7:0] ey;
    logic       b;
    logic       eplot;
    logic [2:0] ecol;
    plots = 0;
    sprite = spr; base_x = bx; base_y = by; fg_colour = fg; bg_colour = bg;
    transparent = tr; erase = er; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check($sformatf("d%0d_busy_k", id), 32'(busy), 32'd1);
    check($sformatf("d%0d_plot_k", id), 32'(plot), 32'd0);
    sprite = ~spr; base_x = bx + 8'd3; base_y = by + 7'd2; fg_colour = ~fg; bg_colour = ~bg;
    transparent = ~tr; erase = ~er;
    for (int p = 0; p < 25; p++) begin
      if (p == poke) start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      r = p / 5;
      c = p % 5;
      b = spr[24 - p];
      ex = {1'b0, bx} + 9'(c);
      ey = {1'b0, by} + 8'(r);
      eplot = !(tr && !er && !b) && (ex < 9'd160) && (ey < 8'd120);
      ecol = er ? bg : (b ? fg : bg);
      check($sformatf("d%0d_p%0d_x", id, p), 32'(x), 32'(ex[7:0]));
      check($sformatf("d%0d_p%0d_y", id, p), 32'(y), 32'(ey[6:0]));
      check($sformatf("d%0d_p%0d_colour", id, p), 32'(colour), 32'(ecol));
      check($sformatf("d%0d_p%0d_plot", id, p), 32'(plot), 32'(eplot));
      check($sformatf("d%0d_p%0d_done", id, p), 32'(done), 32'd0);
      if (plot) plots++;
    end
    check($sformatf("d%0d_plot_count", id), 32'(plots), 32'(exp_plots));
    @(posedge clock); #1;
    check($sformatf("d%0d_done_k26", id), 32'(done), 32'd1);
    check($sformatf("d%0d_busy_k26", id), 32'(busy), 32'd1);
    check($sformatf("d%0d_plot_k26", id), 32'(plot), 32'd0);
    @(posedge clock); #1;
    check($sformatf("d%0d_done_k27", id), 32'(done), 32'd0);
    check($sformatf("d%0d_busy_k27", id), 32'(busy), 32'd0);
    @(posedge clock); #1;
    check($sformatf("d%0d_busy_k28", id), 32'(busy), 32'd0);
    check($sformatf("d%0d_done_k28", id), 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; sprite = '0; base_x = '0; base_y = '0;
    fg_colour = '0; bg_colour = '0; transparent = 1'b0; erase = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Opaque draw: every pixel plotted.
    run_draw(1, RIGHT_A, 8'd10, 7'd20, 3'd6, 3'd0, 1'b0, 1'b0, -1, 25);
    // Transparent draw: only the 18 bitmap ones are plotted.
    run_draw(2, RIGHT_A, 8'd10, 7'd20, 3'd6, 3'd0, 1'b1, 1'b0, -1, 18);
    // Erase overrides transparent.
    run_draw(3, 25'h1FFFFFF, 8'd0, 7'd0, 3'd5, 3'd0, 1'b1, 1'b1, -1, 25);
    // Bottom-right corner: 3 columns x 2 rows survive clipping.
    run_draw(4, RIGHT_A, 8'd157, 7'd118, 3'd6, 3'd0, 1'b0, 1'b0, -1, 6);
    // Start re-pulsed during the draw is dropped.
    run_draw(5, RIGHT_A, 8'd50, 7'd60, 3'd2, 3'd4, 1'b0, 1'b0, 4, 25);

    // Reset mid-draw after pixel 12.
    sprite = RIGHT_A; base_x = 8'd30; base_y = 7'd40; fg_colour = 3'd3; bg_colour = 3'd1;
    transparent = 1'b0; erase = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (13) @(posedge clock);
    #1;
    check("rst_mid_p12_x", 32'(x), 32'd32);
    check("rst_mid_p12_y", 32'(y), 32'd42);
    check("rst_mid_p12_colour", 32'(colour), 32'd1);
    check("rst_mid_p12_plot", 32'(plot), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_mid_plot", 32'(plot), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_x", 32'(x), 32'd0);
    check("rst_mid_y", 32'(y), 32'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("rst_mid_no_done", 32'(dones), 32'd0);
    check("rst_mid_idle_busy", 32'(busy), 32'd0);
    run_draw(6, RIGHT_A, 8'd30, 7'd40, 3'd3, 3'd1, 1'b0, 1'b0, -1, 25);

    // Start held high re-triggers on the first IDLE cycle with the new base.
    sprite = RIGHT_A; base_x = 8'd20; base_y = 7'd30; fg_colour = 3'd7; bg_colour = 3'd2;
    transparent = 1'b0; erase = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    base_x = 8'd40; base_y = 7'd50;
    repeat (25) @(posedge clock);
    #1;
    check("hold_p24_x", 32'(x), 32'd24);
    check("hold_p24_y", 32'(y), 32'd34);
    @(posedge clock); #1;
    check("hold_done_k26", 32'(done), 32'd1);
    @(posedge clock); #1;
    start = 1'b0;
    check("hold_busy_k27", 32'(busy), 32'd1);
    check("hold_done_k27", 32'(done), 32'd0);
    check("hold_plot_k27", 32'(plot), 32'd0);
    @(posedge clock); #1;
    check("hold_p0_x", 32'(x), 32'd40);
    check("hold_p0_y", 32'(y), 32'd50);
    check("hold_p0_colour", 32'(colour), 32'd2);
    check("hold_p0_plot", 32'(plot), 32'd1);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("hold_second_done_count", 32'(dones), 32'd1);
    check("hold_end_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
